shader_loader: RTL

- SPI-mode-0 program loader that sits directly upstream of the shader instruction memory. It drives that memory's shift/load/instr inputs.
- In IDLE it passes the shader core's per-instruction circular-shift request straight through.
- During a host SPI transfer it blocks core shifts and pushes each received byte into the memory tail.
- When the transfer ends, it issues extra circular shifts so the first received byte lands at memory word 0.

---
 rtl/shader_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shader_loader.sv
// SPI-mode-0 program loader in front of the shader instruction memory: passes core
// shifts through when idle, streams received bytes into the memory tail, then rotates.
module shader_loader #(
  parameter int NUM_INSTR   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_ni,
  input  logic       exec_shift_i,
  output logic       mem_shift_o,
  output logic       mem_load_o,
  output logic [7:0] mem_instr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int MW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam int CW = $clog2(NUM_INSTR + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    ALIGN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             sr_q, sr_d;
  logic [7:0]             instr_q, instr_d;
  logic [MW-1:0]          byte_mod_q, byte_mod_d;
  logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]          rot_q, rot_d;
  logic                   load_q, load_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic          sclk_s, mosi_s, cs_s;
  logic          sclk_rise, cs_fall, cs_rise;
  logic [CW-1:0] rot_calc;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Rotation that brings the first byte of the transfer back to word 0.
  assign rot_calc = (byte_mod_q == MW'(0)) ? CW'(0) : (CW'(NUM_INSTR) - CW'(byte_mod_q));

  // Next-state logic for synchronisers, receive datapath and sequencing.
  always_comb begin
    sclk_sync_d[0] = spi_sclk_i;
    mosi_sync_d[0] = spi_mosi_i;
    cs_sync_d[0]   = spi_cs_ni;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync_d[i] = sclk_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
      cs_sync_d[i]   = cs_sync_q[i-1];
    end
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    instr_d     = instr_q;
    byte_mod_d  = byte_mod_q;
    byte_cnt_d  = byte_cnt_q;
    rot_d       = rot_q;
    load_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = RECV;
          bit_cnt_d  = 3'd0;
          sr_d       = 7'd0;
          byte_mod_d = MW'(0);
          byte_cnt_d = CW'(0);
          err_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (cs_rise) begin
          bit_cnt_d = 3'd0;
          if ((bit_cnt_q != 3'd0) || (byte_cnt_q > CW'(NUM_INSTR))) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if ((byte_cnt_q == CW'(0)) || (rot_calc == CW'(0))) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ALIGN;
            rot_d   = rot_calc;
          end
        end else if (sclk_rise) begin
          sr_d = {sr_q[5:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            instr_d    = {sr_q, mosi_s};
            load_d     = 1'b1;
            byte_mod_d = (byte_mod_q == MW'(NUM_INSTR - 1)) ? MW'(0) : (byte_mod_q + MW'(1));
            byte_cnt_d = (byte_cnt_q == CW'(NUM_INSTR + 1)) ? byte_cnt_q : (byte_cnt_q + CW'(1));
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = RECV;
        end
      end
      ALIGN: begin
        rot_d = rot_q - CW'(1);
        // A new transfer cannot start mid-rotation; flag it instead.
        if (cs_fall) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (rot_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ALIGN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      sr_q        <= 7'd0;
      instr_q     <= 8'd0;
      byte_mod_q  <= MW'(0);
      byte_cnt_q  <= CW'(0);
      rot_q       <= CW'(0);
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      instr_q     <= instr_d;
      byte_mod_q  <= byte_mod_d;
      byte_cnt_q  <= byte_cnt_d;
      rot_q       <= rot_d;
      load_q      <= load_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_shift_o = (state_q == IDLE) ? exec_shift_i : (load_q | (state_q == ALIGN));
  assign mem_load_o  = load_q;
  assign mem_instr_o = instr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
